dram_ctrl: RTL and testbench

DRAM_CTRL -- requirements
Module: dram_ctrl

---
 rtl/dram_ctrl_if.sv | 23 ++
 rtl/dram_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_dram_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/dram_ctrl_if.sv
// 68040 transfer-request and DRAM strobe signals shared by dram_ctrl and its bus master.
interface dram_ctrl_if;
  logic       nTS;
  logic       dramsel;
  logic       RnW;
  logic [1:0] SIZ;
  logic       nRAS;
  logic       nCAS;
  logic       nWE;
  logic       MUX;
  logic       nTA;
  logic       nTBI;

  modport master (
    output nTS, dramsel, RnW, SIZ,
    input  nRAS, nCAS, nWE, MUX, nTA, nTBI
  );

  modport slave (
    input  nTS, dramsel, RnW, SIZ,
    output nRAS, nCAS, nWE, MUX, nTA, nTBI
  );
endinterface

// File: rtl/dram_ctrl.sv
// Single-access DRAM controller for a 68040 bus: RAS/CAS sequencing, CAS-before-RAS refresh,
// registered glitch-free strobes decoded from the next state.
module dram_ctrl #(
  parameter int unsigned REFRESH_INTERVAL = 390,
  parameter int unsigned PRECHARGE_CYCLES = 2
) (
  input  logic       BCLK,
  input  logic       RESET,
  dram_ctrl_if.slave bus
);

  localparam int unsigned RI = (REFRESH_INTERVAL < 1) ? 1 : REFRESH_INTERVAL;
  localparam int unsigned PC = (PRECHARGE_CYCLES < 1) ? 1 : PRECHARGE_CYCLES;
  localparam int unsigned RW = (RI > 1) ? $clog2(RI) : 1;
  localparam int unsigned WW = (PC > 1) ? $clog2(PC) : 1;

  localparam logic [RW-1:0] REF_RELOAD = RW'(RI - 1);
  localparam logic [WW-1:0] PRE_LOAD   = WW'(PC - 1);
  localparam logic [WW-1:0] HOLD_LOAD  = WW'(1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ROW,
    S_COL,
    S_CAS,
    S_ACK,
    S_PRE,
    S_REF_CAS,
    S_REF_RAS,
    S_REF_HOLD
  } state_e;

  state_e        state_q, state_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          acc_pend_q, acc_pend_d;
  logic          ref_pend_q, ref_pend_d;
  logic          rnw_q, rnw_d;
  logic [1:0]    siz_q, siz_d;
  logic          capture;
  logic          acc_done;
  logic          ref_done;

  logic nras_q, nras_d;
  logic ncas_q, ncas_d;
  logic nwe_q,  nwe_d;
  logic mux_q,  mux_d;
  logic nta_q,  nta_d;
  logic ntbi_q, ntbi_d;

  // A new request is only accepted while nothing is pending or in service
  assign capture = ~bus.nTS & bus.dramsel & ~acc_pend_q;

  always_comb begin
    acc_pend_d = acc_pend_q;
    rnw_d      = rnw_q;
    siz_d      = siz_q;
    if (capture) begin
      acc_pend_d = 1'b1;
      rnw_d      = bus.RnW;
      siz_d      = bus.SIZ;
    end else if (acc_done) begin
      acc_pend_d = 1'b0;
    end

    // Expiry is applied after the clear so a coincident expiry still queues a refresh
    ref_pend_d = ref_done ? 1'b0 : ref_pend_q;
    rcnt_d     = rcnt_q - 1'b1;
    if (rcnt_q == '0) begin
      ref_pend_d = 1'b1;
      rcnt_d     = REF_RELOAD;
    end
  end

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    acc_done = 1'b0;
    ref_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ref_pend_q) begin
          state_d = S_REF_CAS;
        end else if (acc_pend_q || capture) begin
          state_d = S_ROW;
        end
      end
      S_ROW:     state_d = S_COL;
      S_COL:     state_d = S_CAS;
      S_CAS:     state_d = S_ACK;
      S_ACK: begin
        acc_done = 1'b1;
        state_d  = S_PRE;
        wcnt_d   = PRE_LOAD;
      end
      S_PRE: begin
        if (wcnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          wcnt_d = wcnt_q - 1'b1;
        end
      end
      S_REF_CAS: state_d = S_REF_RAS;
      S_REF_RAS: begin
        state_d = S_REF_HOLD;
        wcnt_d  = HOLD_LOAD;
      end
      S_REF_HOLD: begin
        if (wcnt_q == '0) begin
          ref_done = 1'b1;
          state_d  = S_PRE;
          wcnt_d   = PRE_LOAD;
        end else begin
          wcnt_d = wcnt_q - 1'b1;
        end
      end
      default:   state_d = S_IDLE;
    endcase
  end

  // Strobes are decoded from the next state and registered, so they change cleanly on the edge
  always_comb begin
    nras_d = 1'b1;
    ncas_d = 1'b1;
    nwe_d  = 1'b1;
    mux_d  = 1'b0;
    nta_d  = 1'b1;
    ntbi_d = 1'b1;
    case (state_d)
      S_ROW: begin
        nras_d = 1'b0;
      end
      S_COL: begin
        nras_d = 1'b0;
        mux_d  = 1'b1;
        nwe_d  = rnw_d;
      end
      S_CAS: begin
        nras_d = 1'b0;
        ncas_d = 1'b0;
        mux_d  = 1'b1;
        nwe_d  = rnw_d;
      end
      S_ACK: begin
        nras_d = 1'b0;
        ncas_d = 1'b0;
        mux_d  = 1'b1;
        nwe_d  = rnw_d;
        nta_d  = 1'b0;
        ntbi_d = (siz_d == 2'b11) ? 1'b0 : 1'b1;
      end
      S_REF_CAS: begin
        ncas_d = 1'b0;
      end
      S_REF_RAS, S_REF_HOLD: begin
        ncas_d = 1'b0;
        nras_d = 1'b0;
      end
      default: begin
        nras_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge BCLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      wcnt_q     <= '0;
      rcnt_q     <= REF_RELOAD;
      acc_pend_q <= 1'b0;
      ref_pend_q <= 1'b0;
      nras_q     <= 1'b1;
      ncas_q     <= 1'b1;
      nwe_q      <= 1'b1;
      mux_q      <= 1'b0;
      nta_q      <= 1'b1;
      ntbi_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      rcnt_q     <= rcnt_d;
      acc_pend_q <= acc_pend_d;
      ref_pend_q <= ref_pend_d;
      nras_q     <= nras_d;
      ncas_q     <= ncas_d;
      nwe_q      <= nwe_d;
      mux_q      <= mux_d;
      nta_q      <= nta_d;
      ntbi_q     <= ntbi_d;
    end
  end

  always_ff @(posedge BCLK) begin
    rnw_q <= rnw_d;
    siz_q <= siz_d;
  end

  assign bus.nRAS = nras_q;
  assign bus.nCAS = ncas_q;
  assign bus.nWE  = nwe_q;
  assign bus.MUX  = mux_q;
  assign bus.nTA  = nta_q;
  assign bus.nTBI = ntbi_q;

endmodule

// File: tb/tb_dram_ctrl.sv
// Bench for dram_ctrl: directed bus scenarios with literal strobe patterns, then randomized
// traffic and resets checked every cycle against a sequence-template model.
module tb_dram_ctrl;
  localparam int RI = 8;
  localparam int PC = 2;

  localparam logic [5:0] V_IDLE = 6'b111011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  dram_ctrl_if bus();

  dram_ctrl #(.REFRESH_INTERVAL(RI), .PRECHARGE_CYCLES(PC)) dut (
    .BCLK  (clk),
    .RESET (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // {nRAS, nCAS, nWE, MUX, nTA, nTBI}
  wire [5:0] outv = {bus.nRAS, bus.nCAS, bus.nWE, bus.MUX, bus.nTA, bus.nTBI};

  // Model: each bus operation is a fixed list of per-cycle strobe vectors.
  // tag 0 = ordinary cycle, 1 = acknowledge cycle, 2 = last refresh hold cycle, 3 = idle.
  typedef struct packed {
    logic [5:0] o;
    logic [1:0] tag;
  } slot_t;

  slot_t      q[$];
  slot_t      cur;
  int         m_cnt;
  bit         m_ref, m_acc, m_rnw, m_valid, m_cap;
  logic [1:0] m_siz;

  function automatic slot_t mk(input logic [5:0] o, input logic [1:0] tag);
    slot_t r;
    r.o   = o;
    r.tag = tag;
    return r;
  endfunction

  task automatic model_step();
    logic w, tb;
    if (rst) begin
      q.delete();
      cur     = mk(V_IDLE, 2'd3);
      m_cnt   = RI - 1;
      m_ref   = 1'b0;
      m_acc   = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_cap = !bus.nTS && bus.dramsel && !m_acc;
      if (m_cap) begin
        m_rnw = bus.RnW;
        m_siz = bus.SIZ;
      end
      if (cur.tag == 2'd3) begin
        if (m_ref) begin
          q.push_back(mk(6'b101011, 2'd0));
          q.push_back(mk(6'b001011, 2'd0));
          q.push_back(mk(6'b001011, 2'd0));
          q.push_back(mk(6'b001011, 2'd2));
          for (int i = 0; i < PC; i++) q.push_back(mk(V_IDLE, 2'd0));
        end else if (m_acc || m_cap) begin
          w  = m_rnw;
          tb = (m_siz == 2'b11) ? 1'b0 : 1'b1;
          q.push_back(mk(6'b011011, 2'd0));
          q.push_back(mk({2'b01, w, 3'b111}, 2'd0));
          q.push_back(mk({2'b00, w, 3'b111}, 2'd0));
          q.push_back(mk({2'b00, w, 2'b10, tb}, 2'd1));
          for (int i = 0; i < PC; i++) q.push_back(mk(V_IDLE, 2'd0));
        end
      end else begin
        if (cur.tag == 2'd1) m_acc = 1'b0;
        if (cur.tag == 2'd2) m_ref = 1'b0;
      end
      if (m_cap) m_acc = 1'b1;
      if (m_cnt == 0) begin
        m_ref = 1'b1;
        m_cnt = RI - 1;
      end else begin
        m_cnt = m_cnt - 1;
      end
      cur = (q.size() > 0) ? q.pop_front() : mk(V_IDLE, 2'd3);
    end
  endtask

  initial begin
    m_valid = 1'b0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        tests++;
        if (outv !== cur.o) begin
          fails++;
          $display("FAIL model_cmp t=%0t dut=%b expected=%b", $time, outv, cur.o);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [5:0] exp);
    tests++;
    if (outv !== exp) begin
      fails++;
      $display("FAIL %s dut=%b expected=%b", nm, outv, exp);
    end
  endtask

  task automatic idle_in();
    bus.nTS     = 1'b1;
    bus.dramsel = 1'b0;
    bus.RnW     = 1'b1;
    bus.SIZ     = 2'b00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_in();
    repeat (2) @(negedge clk);
  endtask

  logic [5:0] ex [24];

  // Releases reset, drives one access at negedge acc_at (-1 = none), checks cycles 0..ncyc against ex.
  task automatic scenario(input string nm, input int acc_at, input logic dsel,
                          input logic rnw, input logic [1:0] siz, input int ncyc);
    do_reset();
    rst = 1'b0;
    for (int k = 0; k <= ncyc; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("%s_c%0d", nm, k), ex[k]);
      if (k == acc_at) begin
        bus.nTS     = 1'b0;
        bus.dramsel = dsel;
        bus.RnW     = rnw;
        bus.SIZ     = siz;
      end else begin
        idle_in();
      end
    end
  endtask

  initial begin
    idle_in();
    rst = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 24; i++) ex[i] = V_IDLE;
    ex[1] = 6'b011011; ex[2] = 6'b011111; ex[3] = 6'b001111; ex[4] = 6'b001101;
    scenario("read", 0, 1'b1, 1'b1, 2'b00, 8);

    for (int i = 0; i < 24; i++) ex[i] = V_IDLE;
    ex[1] = 6'b011011; ex[2] = 6'b010111; ex[3] = 6'b000111; ex[4] = 6'b000100;
    scenario("line_wr", 0, 1'b1, 1'b0, 2'b11, 8);

    for (int i = 0; i < 24; i++) ex[i] = V_IDLE;
    scenario("nondram", 0, 1'b0, 1'b1, 2'b00, 8);

    for (int i = 0; i < 24; i++) ex[i] = V_IDLE;
    ex[9] = 6'b101011; ex[10] = 6'b001011; ex[11] = 6'b001011; ex[12] = 6'b001011;
    ex[17] = 6'b101011;
    scenario("refresh", -1, 1'b1, 1'b1, 2'b00, 17);

    for (int i = 0; i < 24; i++) ex[i] = V_IDLE;
    ex[9] = 6'b101011; ex[10] = 6'b001011; ex[11] = 6'b001011; ex[12] = 6'b001011;
    ex[16] = 6'b011011; ex[17] = 6'b011111; ex[18] = 6'b001111; ex[19] = 6'b001101;
    ex[23] = 6'b101011;
    scenario("collide", 8, 1'b1, 1'b1, 2'b00, 23);

    // Reset while in CAS, then a fresh read
    do_reset();
    rst = 1'b0;
    bus.nTS = 1'b0; bus.dramsel = 1'b1; bus.RnW = 1'b1; bus.SIZ = 2'b00;
    @(negedge clk); idle_in();
    @(negedge clk);
    @(negedge clk); check("rstcas_c3", 6'b001111);
    rst = 1'b1;
    @(negedge clk); check("rstcas_c4", V_IDLE);
    rst = 1'b0;
    bus.nTS = 1'b0; bus.dramsel = 1'b1; bus.RnW = 1'b1; bus.SIZ = 2'b00;
    @(negedge clk); check("rstcas_c5", 6'b011011); idle_in();
    @(negedge clk); check("rstcas_c6", 6'b011111);
    @(negedge clk); check("rstcas_c7", 6'b001111);
    @(negedge clk); check("rstcas_c8", 6'b001101);
    @(negedge clk); check("rstcas_c9", V_IDLE);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      rst         = ($urandom_range(0, 299) == 0);
      bus.nTS     = ($urandom_range(0, 99) < 35) ? 1'b0 : 1'b1;
      bus.dramsel = ($urandom_range(0, 3) != 0);
      bus.RnW     = 1'($urandom);
      bus.SIZ     = 2'($urandom);
    end

    @(negedge clk);
    idle_in();
    rst = 1'b0;
    repeat (20) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
